// File: rtl/mul_seq_approx_if.sv
// Operand/result handshake bundle for the sequential approximate multiplier.
interface mul_seq_approx_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           MODE;
    logic           IN_VALID;
    logic           IN_READY;
    logic [2*W-1:0] O;
    logic           OUT_VALID;
    logic           OUT_READY;

    // Producer/consumer side of the block.
    modport master (
        output A, B, MODE, IN_VALID, OUT_READY,
        input  IN_READY, O, OUT_VALID
    );

    // Multiplier side.
    modport slave (
        input  A, B, MODE, IN_VALID, OUT_READY,
        output IN_READY, O, OUT_VALID
    );
endinterface

// File: rtl/mul_seq_approx.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, with
// run-time selectable column truncation below weight 2^K and optional
// constant bias compensation on bit K-1.
module mul_seq_approx #(
    parameter int unsigned W    = 8,
    parameter int unsigned K    = 4,
    parameter int unsigned COMP = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    mul_seq_approx_if.slave  bus
);
    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;
    // Index of the compensation bit; clamped so it is always a legal index.
    localparam int unsigned CB = (K > 0) ? K - 1 : 0;
    localparam bit          COMP_EN = (COMP == 1) && (K > 0);
    localparam logic [PW-1:0] KEEP_MASK = ~((PW'(1) << K) - PW'(1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [PW-1:0]  a_sh;
    logic [W-1:0]   b_sh;
    logic [PW-1:0]  acc;
    logic [PW-1:0]  o_q;
    logic [CW-1:0]  cnt;
    logic           mode_q;
    logic           a_nz;
    logic           b_nz;
    logic           in_ready_q;
    logic           out_valid_q;

    logic [PW-1:0]  addend_c;
    logic [PW-1:0]  acc_sum_c;
    logic [PW-1:0]  result_c;
    logic           last_step_c;

    // Partial-product selection, truncation and accumulation for this step.
    always_comb begin
        addend_c = b_sh[0] ? a_sh : '0;
        if (mode_q) begin
            addend_c = addend_c & KEEP_MASK;
        end
        acc_sum_c   = acc + addend_c;
        last_step_c = (cnt == CW'(W - 1));
        result_c    = acc_sum_c;
        if (COMP_EN && mode_q && a_nz && b_nz) begin
            result_c[CB] = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.IN_VALID) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last_step_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.OUT_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and registered handshake decodes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state_nxt == DONE);
        end
    end

    // Operand capture, shift-add step and result capture on entry to DONE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            o_q    <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
            a_nz   <= 1'b0;
            b_nz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.IN_VALID) begin
                        a_sh   <= PW'(bus.A);
                        b_sh   <= bus.B;
                        mode_q <= bus.MODE;
                        a_nz   <= |bus.A;
                        b_nz   <= |bus.B;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    acc  <= acc_sum_c;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    if (last_step_c) begin
                        o_q <= result_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.O         = o_q;

endmodule

// File: tb/tb_mul_seq_approx.sv
// Scoreboard bench: three instances (K=4/COMP=1, K=4/COMP=0, K=0/COMP=1)
// share one stimulus stream; expected results are queued at input accept.
module tb_mul_seq_approx;
    localparam int unsigned W = 8;

    logic CLK;
    logic RST_N;

    mul_seq_approx_if #(.W(W)) b0 ();
    mul_seq_approx_if #(.W(W)) b1 ();
    mul_seq_approx_if #(.W(W)) b2 ();

    mul_seq_approx #(.W(W), .K(4), .COMP(1)) u0 (.CLK(CLK), .RST_N(RST_N), .bus(b0));
    mul_seq_approx #(.W(W), .K(4), .COMP(0)) u1 (.CLK(CLK), .RST_N(RST_N), .bus(b1));
    mul_seq_approx #(.W(W), .K(0), .COMP(1)) u2 (.CLK(CLK), .RST_N(RST_N), .bus(b2));

    assign b1.A = b0.A;   assign b1.B = b0.B;   assign b1.MODE = b0.MODE;
    assign b1.IN_VALID = b0.IN_VALID;           assign b1.OUT_READY = b0.OUT_READY;
    assign b2.A = b0.A;   assign b2.B = b0.B;   assign b2.MODE = b0.MODE;
    assign b2.IN_VALID = b0.IN_VALID;           assign b2.OUT_READY = b0.OUT_READY;

    typedef struct {
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
        int          acc_edge;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   rmode = 1;   // 0 random ready, 1 always ready, 2 left to the sequence
    logic        prev_ov = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [15:0] held = '0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference: sum of partial products, each truncated below 2^k when approximating.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic mode, input int k, input int comp);
        int unsigned sum = 0;
        int unsigned pp;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                pp = int'(a) * (1 << i);
                if (mode && k > 0) pp = pp - (pp % (1 << k));
                sum += pp;
            end
        end
        if (mode && comp == 1 && k > 0 && a != 0 && b != 0) sum = sum | (1 << (k - 1));
        return 16'(sum);
    endfunction

    // Consumer ready driver.
    initial begin
        b0.OUT_READY = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (rmode == 0) b0.OUT_READY = ($urandom_range(0, 3) != 0);
            else if (rmode == 1) b0.OUT_READY = 1'b1;
        end
    end

    // Monitor: latency, hold-stability, and scoreboard comparison on output handshake.
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_ov  = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            if (b0.IN_READY && b0.OUT_VALID) chk("ready_valid_exclusive", 1, 0);
            if (prev_ov && !prev_rdy) begin
                chk("hold_out_valid", b0.OUT_VALID, 1);
                chk("hold_o_stable", b0.O, held);
            end
            if (b0.OUT_VALID && !prev_ov) begin
                if (sbq.size() == 0) chk("unexpected_result", 1, 0);
                else chk("latency_edges", 32'(cyc - sbq[0].acc_edge), W);
            end
            if (b0.OUT_VALID && b0.OUT_READY) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_handshake", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("o_k4_comp1", b0.O, e.e0);
                    chk("o_k4_comp0", {b1.OUT_VALID, b1.O}, {1'b1, e.e1});
                    chk("o_k0_exact", {b2.OUT_VALID, b2.O}, {1'b1, e.e2});
                end
            end
            prev_ov  = b0.OUT_VALID;
            prev_rdy = b0.OUT_READY;
            held     = b0.O;
        end
    end

    // Present operands until accepted; called at posedge+1, returns at posedge+1.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic m,
                         input bit given, input logic [15:0] g0, input logic [15:0] g1);
        exp_t e;
        int   n = 0;
        b0.A = a; b0.B = b; b0.MODE = m; b0.IN_VALID = 1'b1;
        forever begin
            @(negedge CLK);
            if (b0.IN_READY) break;
            n++;
            if (n > 200) begin
                bound_fail("input_accept");
                @(posedge CLK); #1;
                b0.IN_VALID = 1'b0;
                return;
            end
        end
        e.e0 = given ? g0 : model(a, b, m, 4, 1);
        e.e1 = given ? g1 : model(a, b, m, 4, 0);
        e.e2 = 16'(int'(a) * int'(b));
        e.acc_edge = cyc + 1;
        last_acc = cyc + 1;
        sbq.push_back(e);
        @(posedge CLK); #1;
        b0.IN_VALID = 1'b0;
        b0.A = 8'($urandom); b0.B = 8'($urandom); b0.MODE = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 || b0.OUT_VALID) begin
            @(posedge CLK); #1;
            n++;
            if (n > 400) begin
                bound_fail("drain");
                sbq.delete();
                return;
            end
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int t0;
        int n;
        RST_N = 1'b0;
        b0.A = '0; b0.B = '0; b0.MODE = 1'b0; b0.IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_in_ready", b0.IN_READY, 1);
        chk("rst_out_valid", b0.OUT_VALID, 0);
        chk("rst_o", b0.O, 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Directed cases with hand-derived results for K=4 COMP=1 and COMP=0.
        rmode = 1;
        issue(8'd255, 8'd255, 1'b0, 1, 16'd65025, 16'd65025);
        issue(8'd0,   8'd200, 1'b0, 1, 16'd0,     16'd0);
        issue(8'd255, 8'd255, 1'b1, 1, 16'd64984, 16'd64976);
        issue(8'd15,  8'd1,   1'b1, 1, 16'd8,     16'd0);
        issue(8'd0,   8'd255, 1'b1, 1, 16'd0,     16'd0);
        issue(8'd16,  8'd1,   1'b1, 1, 16'd24,    16'd16);

        // Back-to-back throughput with ready held high.
        t0 = last_acc;
        issue(8'd7, 8'd9, 1'b1, 0, '0, '0);
        chk("throughput_edges", 32'(last_acc - t0), W + 2);
        drain();

        // Back-pressure: result held, new request ignored while DONE.
        rmode = 2;
        b0.OUT_READY = 1'b0;
        issue(8'd200, 8'd100, 1'b0, 1, 16'd20000, 16'd20000);
        n = 0;
        while (!b0.OUT_VALID) begin
            @(negedge CLK);
            n++;
            if (n > 40) begin bound_fail("bp_out_valid"); break; end
        end
        @(posedge CLK); #1;
        b0.A = 8'd7; b0.B = 8'd7; b0.MODE = 1'b0; b0.IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_out_valid", b0.OUT_VALID, 1);
            chk("bp_in_ready", b0.IN_READY, 0);
            chk("bp_o", b0.O, 16'd20000);
        end
        @(posedge CLK); #1;
        b0.IN_VALID = 1'b0;
        b0.OUT_READY = 1'b1;
        @(posedge CLK); #1;
        chk("bp_release_idle", {b0.IN_READY, b0.OUT_VALID}, 2'b10);
        rmode = 1;
        drain();

        // Reset during BUSY step 3 discards the transaction.
        issue(8'd100, 8'd100, 1'b1, 0, '0, '0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        sbq.delete();
        #1;
        chk("midrst_in_ready", b0.IN_READY, 1);
        chk("midrst_out_valid", b0.OUT_VALID, 0);
        chk("midrst_o", b0.O, 0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        issue(8'd3, 8'd5, 1'b0, 1, 16'd15, 16'd15);
        drain();

        // Randomised sweep with corner-biased operands and random stalls.
        rmode = 0;
        for (int i = 0; i < 2500; i++) begin
            case ($urandom_range(0, 7))
                0: ra = 8'd0;
                1: ra = 8'd255;
                default: ra = 8'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: rb = 8'd0;
                1: rb = 8'd255;
                default: rb = 8'($urandom);
            endcase
            issue(ra, rb, 1'($urandom), 0, '0, '0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
